// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Target end of the CPU data-memory interface. Accepts one request at a
//   time, holds it for LATENCY cycles, then commits the write or returns the
//   read word together with a one-cycle data_valid strobe.
//
// Parameters
//   MEM_WORDS_LOG2 : log2 of storage depth in 16-bit words
//   LATENCY        : cycles from acceptance to response, 1..15
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   enable     in   request strobe, sampled only while busy=0
//   wr         in   1 = write, 0 = read
//   addr[15:0] in   byte address, word index = addr[MEM_WORDS_LOG2:1]
//   data_in    in   write data
//   busy       out  request in flight, new requests are dropped
//   data_valid out  one-cycle completion strobe (reads and writes)
//   data_out   out  read data, holds its value except on read completion
//   err        out  misaligned-access flag (only with the macro below)
//
// Build option
//   DATA_MEM_ALIGN_CHECK_EN : when defined, a request with addr[0]=1 runs the
//   full latency but does not touch memory or data_out and completes with
//   err=1. When undefined, addr[0] is ignored and err is tied to 0.
//
// State | meaning
//   IDLE  | no request in flight, enable is sampled
//   WAIT  | request captured, cnt counts down to completion

module data_mem_responder #(
  parameter int MEM_WORDS_LOG2 = 10,
  parameter int LATENCY        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic        busy,
  output logic        data_valid,
  output logic [15:0] data_out,
  output logic        err
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;
  // Acceptance edge plus LATENCY-2 decrements plus the completion edge.
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic wr_q, wr_d;
  logic [MEM_WORDS_LOG2-1:0] idx_q, idx_d;
  logic [15:0] wdata_q, wdata_d;
  logic mis_q, mis_d;
  logic busy_q, busy_d;
  logic data_valid_q, data_valid_d;
  logic [15:0] data_out_q, data_out_d;

  // Completion-side view of the request: the captured copy normally, the live
  // inputs when LATENCY=1 completes at the acceptance edge itself.
  logic cmp_fire;
  logic cmp_wr;
  logic [MEM_WORDS_LOG2-1:0] cmp_idx;
  logic [15:0] cmp_data;
  logic cmp_mis;
  logic cmp_blocked;
  logic mem_we;

  logic [15:0] mem [DEPTH];

  // Address bits above the word index alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr[15:MEM_WORDS_LOG2+1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    mis_d        = mis_q;
    data_valid_d = 1'b0;
    data_out_d   = data_out_q;
    cmp_fire     = 1'b0;
    cmp_wr       = wr_q;
    cmp_idx      = idx_q;
    cmp_data     = wdata_q;
    cmp_mis      = mis_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          wr_d    = wr;
          idx_d   = addr[MEM_WORDS_LOG2:1];
          wdata_d = data_in;
          mis_d   = addr[0];
          if (LATENCY == 1) begin
            cmp_fire = 1'b1;
            cmp_wr   = wr;
            cmp_idx  = addr[MEM_WORDS_LOG2:1];
            cmp_data = data_in;
            cmp_mis  = addr[0];
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cmp_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cmp_blocked = cmp_mis & ALIGN_CHK;
    if (cmp_fire) begin
      data_valid_d = 1'b1;
      if (!cmp_wr && !cmp_blocked) begin
        data_out_d = mem[cmp_idx];
      end
    end

    busy_d = (state_d == WAIT);
  end

  // Gated by rst so a request presented while reset is held never commits.
  assign mem_we = cmp_fire & cmp_wr & ~cmp_blocked & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 16'h0000;
      mis_q        <= 1'b0;
      busy_q       <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      mis_q        <= mis_d;
      busy_q       <= busy_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[cmp_idx] <= cmp_data;
    end
  end

`ifdef DATA_MEM_ALIGN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = cmp_fire & cmp_blocked;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign busy       = busy_q;
  assign data_valid = data_valid_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam int LAT   = 4;
  localparam int LOG2  = 10;
  localparam int DEPTH = 1 << LOG2;
`ifdef DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        enable = 1'b0, wr = 1'b0;
  logic [15:0] addr = 16'h0, data_in = 16'h0;
  logic        busy, data_valid, err;
  logic [15:0] data_out;

  logic        en1 = 1'b0, wr1 = 1'b0;
  logic [15:0] addr1 = 16'h0, din1 = 16'h0;
  logic        busy1, dv1, err1;
  logic [15:0] dout1;

  data_mem_responder #(.MEM_WORDS_LOG2(LOG2), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .busy(busy), .data_valid(data_valid),
    .data_out(data_out), .err(err)
  );

  data_mem_responder #(.MEM_WORDS_LOG2(LOG2), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .wr(wr1), .addr(addr1),
    .data_in(din1), .busy(busy1), .data_valid(dv1),
    .data_out(dout1), .err(err1)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: a request accepted at edge a completes at
  // edge a+LAT-1; the model is idle again from edge a+LAT on.
  int          edge_n = 0;
  bit          pend = 1'b0;
  int          acc_edge = 0;
  bit          p_wr, p_mis;
  int          p_idx;
  logic [15:0] p_data;
  logic [15:0] mmem [DEPTH];
  bit          mknown [DEPTH];
  logic [15:0] exp_dout = 16'h0;
  bit          dout_known = 1'b1;
  bit          exp_busy = 1'b0, exp_dv = 1'b0, exp_err = 1'b0;

  function automatic int widx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  task automatic complete();
    exp_dv = 1'b1;
    if (p_mis && ALIGN) begin
      exp_err = 1'b1;
    end else if (p_wr) begin
      mmem[p_idx]   = p_data;
      mknown[p_idx] = 1'b1;
    end else begin
      exp_dout   = mmem[p_idx];
      dout_known = mknown[p_idx];
    end
  endtask

  task automatic model_reset();
    pend       = 1'b0;
    exp_dout   = 16'h0;
    dout_known = 1'b1;
    exp_busy   = 1'b0;
    exp_dv     = 1'b0;
    exp_err    = 1'b0;
  endtask

  // One clock: advance model at the rising edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    edge_n++;
    exp_dv  = 1'b0;
    exp_err = 1'b0;
    if (pend) begin
      if (edge_n == acc_edge + LAT - 1) begin
        pend = 1'b0;
        complete();
      end
    end else if (enable) begin
      acc_edge = edge_n;
      p_wr     = wr;
      p_idx    = widx(addr);
      p_data   = data_in;
      p_mis    = addr[0];
      if (LAT == 1) complete();
      else pend = 1'b1;
    end
    exp_busy = pend;
    @(negedge clk);
    chk("busy", 16'(busy), 16'(exp_busy));
    chk("data_valid", 16'(data_valid), 16'(exp_dv));
    chk("err", 16'(err), 16'(exp_err));
    if (dout_known) chk("data_out", data_out, exp_dout);
  endtask

  // Issue one request from idle and run to its data_valid cycle.
  task automatic issue(input bit w, input logic [15:0] a, input logic [15:0] d,
                       output int lat, output int bcyc, output logic [15:0] rd,
                       output logic e);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    step();
    enable = 1'b0;
    lat  = 1;
    bcyc = busy ? 1 : 0;
    while (!data_valid && lat < 20) begin
      step();
      lat++;
      if (busy) bcyc++;
    end
    rd = data_out;
    e  = err;
  endtask

  typedef struct {
    bit          w;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t tbl [11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, bcyc;
    logic [15:0] rd;
    logic e;

    tbl[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    tbl[2]  = '{1'b1, 16'h0002, 16'h1234, 16'hBEEF};
    tbl[3]  = '{1'b0, 16'h0802, 16'h0000, 16'h1234};
    tbl[4]  = '{1'b1, 16'h0004, 16'h0000, 16'h1234};
    tbl[5]  = '{1'b0, 16'h0004, 16'h0000, 16'h0000};
    tbl[6]  = '{1'b1, 16'h07FE, 16'hCAFE, 16'h0000};
    tbl[7]  = '{1'b0, 16'h0FFE, 16'h0000, 16'hCAFE};
    tbl[8]  = '{1'b1, 16'h0000, 16'h0001, 16'hCAFE};
    tbl[9]  = '{1'b0, 16'hF800, 16'h0000, 16'h0001};
    tbl[10] = '{1'b1, 16'h0020, 16'h5555, 16'h0001};

    for (int i = 0; i < DEPTH; i++) mknown[i] = 1'b0;

    // Power-on reset
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_dv", 16'(data_valid), 16'h0);
    chk("rst_dout", data_out, 16'h0000);
    chk("rst_err", 16'(err), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed table, issued back to back (each accepted in the previous
    // request's data_valid cycle)
    for (int i = 0; i < 11; i++) begin
      issue(tbl[i].w, tbl[i].a, tbl[i].d, lat, bcyc, rd, e);
      chk("tbl_latency", 16'(lat), 16'(LAT));
      chk("tbl_busy_cycles", 16'(bcyc), 16'(LAT - 1));
      chk("tbl_data_out", rd, tbl[i].exp_rd);
    end

    // Write presented while busy is dropped
    enable = 1'b1; wr = 1'b0; addr = 16'h0010; data_in = 16'h0;
    step();
    wr = 1'b1; addr = 16'h0004; data_in = 16'hFFFF;
    repeat (LAT - 1) step();
    enable = 1'b0;
    chk("drop_dv", 16'(data_valid), 16'h1);
    chk("drop_rd", data_out, 16'hBEEF);
    issue(1'b0, 16'h0004, 16'h0, lat, bcyc, rd, e);
    chk("drop_mem", rd, 16'h0000);

    // Reset two cycles into a write
    enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'hAAAA;
    step();
    enable = 1'b0;
    step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_busy", 16'(busy), 16'h0);
    chk("midrst_dv", 16'(data_valid), 16'h0);
    chk("midrst_dout", data_out, 16'h0000);
    for (int i = 0; i < LAT; i++) begin
      @(negedge clk);
      chk("midrst_hold_dv", 16'(data_valid), 16'h0);
    end
    rst = 1'b0;
    issue(1'b0, 16'h0020, 16'h0, lat, bcyc, rd, e);
    chk("midrst_mem", rd, 16'h5555);

    // Misaligned write
    issue(1'b1, 16'h0021, 16'h7777, lat, bcyc, rd, e);
    chk("mis_err", 16'(e), 16'(ALIGN));
    chk("mis_dout", rd, 16'h5555);
    issue(1'b0, 16'h0020, 16'h0, lat, bcyc, rd, e);
    chk("mis_mem", rd, ALIGN ? 16'h5555 : 16'h7777);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] sidx;
      sidx    = 3'($urandom_range(0, 7));
      enable  = 1'($urandom_range(0, 1));
      wr      = 1'($urandom_range(0, 1));
      addr    = {5'($urandom), 7'd0, sidx, 1'($urandom)};
      data_in = 16'($urandom);
      step();
    end
    enable = 1'b0;
    repeat (LAT) step();

    // LATENCY=1 instance: one request per cycle, alternating write/read
    begin
      logic [15:0] mm1 [8];
      logic [15:0] e_d1;
      bit          op_w, have_w;
      int          last_idx;
      e_d1 = 16'h0; op_w = 1'b1; have_w = 1'b0; last_idx = 0;
      for (int i = 0; i < 60; i++) begin
        int k;
        @(negedge clk);
        en1 = ($urandom_range(0, 3) != 0);
        if (!have_w) op_w = 1'b1;
        wr1 = op_w;
        k = op_w ? int'($urandom_range(0, 7)) : last_idx;
        addr1 = 16'(k * 2);
        din1  = 16'($urandom);
        @(posedge clk);
        if (en1) begin
          if (op_w) begin
            mm1[k]   = din1;
            last_idx = k;
            have_w   = 1'b1;
          end else begin
            e_d1 = mm1[k];
          end
        end
        #1;
        chk("l1_busy", 16'(busy1), 16'h0);
        chk("l1_dv", 16'(dv1), 16'(en1));
        chk("l1_dout", dout1, e_d1);
        if (en1) op_w = ~op_w;
      end
      @(negedge clk);
      en1 = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
